// File: rtl/int_gateway_w4.sv
// int_gateway_w4: four-source interrupt gateway with IDLE/PENDING/INFLIGHT
// tracking per source, lowest-index arbitration and a claim/complete handshake.
// Optional build macro INT_GATEWAY_EDGE_COUNT_EN adds per-source 3-bit
// saturating counters that remember edges arriving while a source is busy.
module int_gateway_w4 #(
  parameter int unsigned N_SRC = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [N_SRC-1:0] io_irq,
  input  logic [N_SRC-1:0] io_enable,
  input  logic [N_SRC-1:0] io_edge_mode,
  output logic             io_req_valid,
  output logic [1:0]       io_req_id,
  input  logic             io_claim,
  input  logic             io_complete_valid,
  input  logic [1:0]       io_complete_id,
  output logic [N_SRC-1:0] io_pending,
  output logic [N_SRC-1:0] io_inflight
);

  localparam int unsigned ID_W = 2;

  // Only the four-source configuration is supported.
  if (N_SRC != 4) begin : g_bad_n_src
    $error("int_gateway_w4: N_SRC must be 4");
  end

  // Encoding chosen so PENDING/INFLIGHT outputs are plain register bits.
  typedef enum logic [1:0] {
    ST_IDLE     = 2'b00,
    ST_PENDING  = 2'b01,
    ST_INFLIGHT = 2'b10
  } state_e;

  state_e           state_q [N_SRC];
  state_e           state_d [N_SRC];
  logic [N_SRC-1:0] irq_prev_q;   // previous io_irq sample (edge detect)
  logic [N_SRC-1:0] trig_c;
  logic [N_SRC-1:0] claim_hit_c;
  logic [N_SRC-1:0] comp_hit_c;

  // Level sources trigger on io_irq; edge sources only on a 0->1 step.
  assign trig_c      = io_irq & ~(io_edge_mode & irq_prev_q);
  assign claim_hit_c = (io_claim && io_req_valid) ? (N_SRC'(1) << io_req_id) : '0;
  assign comp_hit_c  = io_complete_valid ? (N_SRC'(1) << io_complete_id) : '0;

`ifdef INT_GATEWAY_EDGE_COUNT_EN
  localparam int unsigned CNT_W   = 3;
  localparam int unsigned CNT_MAX = 7;

  logic [CNT_W-1:0] cnt_q [N_SRC];
  logic [CNT_W-1:0] cnt_d [N_SRC];
  logic [N_SRC-1:0] cnt_inc_c;
  logic [N_SRC-1:0] cnt_dec_c;

  // Edges seen while busy are banked; a completion with a banked edge re-pends.
  for (genvar g = 0; g < N_SRC; g++) begin : g_cnt
    assign cnt_inc_c[g] = io_edge_mode[g] & trig_c[g] & (state_q[g] != ST_IDLE);
    assign cnt_dec_c[g] = comp_hit_c[g] & (state_q[g] == ST_INFLIGHT) & (cnt_q[g] != '0);
  end

  // Saturating edge counter next-state; simultaneous inc/dec cancel.
  always_comb begin
    for (int i = 0; i < N_SRC; i++) begin
      cnt_d[i] = cnt_q[i];
      if (cnt_inc_c[i] && !cnt_dec_c[i] && (cnt_q[i] != CNT_W'(CNT_MAX))) begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end else if (cnt_dec_c[i] && !cnt_inc_c[i]) begin
        cnt_d[i] = cnt_q[i] - CNT_W'(1);
      end
    end
  end
`endif

  // State register, edge-detect history and optional counters.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < N_SRC; i++) begin
        state_q[i] <= ST_IDLE;
`ifdef INT_GATEWAY_EDGE_COUNT_EN
        cnt_q[i]   <= '0;
`endif
      end
      irq_prev_q <= '0;
    end else begin
      for (int i = 0; i < N_SRC; i++) begin
        state_q[i] <= state_d[i];
`ifdef INT_GATEWAY_EDGE_COUNT_EN
        cnt_q[i]   <= cnt_d[i];
`endif
      end
      irq_prev_q <= io_irq;
    end
  end

  // Per-source next-state logic; triggers while busy are dropped (or banked).
  always_comb begin
    for (int i = 0; i < N_SRC; i++) begin
      state_d[i] = state_q[i];
      case (state_q[i])
        ST_IDLE: begin
          if (trig_c[i] && io_enable[i]) state_d[i] = ST_PENDING;
        end
        ST_PENDING: begin
          if (claim_hit_c[i]) state_d[i] = ST_INFLIGHT;
        end
        ST_INFLIGHT: begin
          if (comp_hit_c[i]) begin
`ifdef INT_GATEWAY_EDGE_COUNT_EN
            state_d[i] = (cnt_q[i] != '0) ? ST_PENDING : ST_IDLE;
`else
            state_d[i] = ST_IDLE;
`endif
          end
        end
        default: state_d[i] = ST_IDLE;
      endcase
    end
  end

  // Output decode and lowest-index arbitration among enabled PENDING sources.
  always_comb begin
    io_req_valid = 1'b0;
    io_req_id    = '0;
    io_pending   = '0;
    io_inflight  = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      io_pending[i]  = (state_q[i] == ST_PENDING);
      io_inflight[i] = (state_q[i] == ST_INFLIGHT);
      if ((state_q[i] == ST_PENDING) && io_enable[i]) begin
        io_req_valid = 1'b1;
        io_req_id    = ID_W'(i);
      end
    end
  end

endmodule

// File: doc/int_gateway_w4.md
INT_GATEWAY_W4 -- requirements
Module: int_gateway_w4

Interface
REQ-001 SHALL have parameter N_SRC, default 4, number of interrupt sources; fixed at 4, and any other value is an elaboration error.
REQ-002 SHALL have port clock, input, 1, the single clock for all state.
REQ-003 SHALL have port reset, input, 1, synchronous, active-high reset.
REQ-004 SHALL have port io_irq, input, 4, per-source interrupt levels already synchronized to clock by the upstream 3-stage async-reset synchronizer.
REQ-005 SHALL have port io_enable, input, 4, per-source enable.
REQ-006 SHALL have port io_edge_mode, input, 4, per-source trigger mode (1 = rising edge, 0 = level).
REQ-007 SHALL have port io_req_valid, output, 1, a claimable source exists.
REQ-008 SHALL have port io_req_id, output, 2, index of the claimable source.
REQ-009 SHALL have port io_claim, input, 1, claim strobe.
REQ-010 SHALL have port io_complete_valid, input, 1, completion strobe.
REQ-011 SHALL have port io_complete_id, input, 2, source being completed.
REQ-012 SHALL have port io_pending, output, 4, per-source PENDING state.
REQ-013 SHALL have port io_inflight, output, 4, per-source INFLIGHT state.

Function
REQ-014 SHALL keep one FSM per source with states IDLE, PENDING and INFLIGHT, plus a 1-bit register irq_d per source holding the previous io_irq.
REQ-015 SHALL define trig[i] as io_irq[i] in level mode and as io_irq[i] & ~irq_d[i] in edge mode.
REQ-016 SHALL move source i from IDLE to PENDING in the next cycle when trig[i] & io_enable[i], giving 1-cycle latency from io_irq to io_pending.
REQ-017 SHALL drive io_req_valid combinationally as OR over i of (PENDING[i] & io_enable[i]).
REQ-018 SHALL drive io_req_id as the lowest such index, and as 0 when io_req_valid is low.
REQ-019 SHALL accept a claim only when io_claim & io_req_valid; source io_req_id then moves PENDING to INFLIGHT in the next cycle, and io_claim with io_req_valid low is ignored.
REQ-020 SHALL move source io_complete_id from INFLIGHT to IDLE on io_complete_valid; completion of a source not in INFLIGHT is ignored with no state change.
REQ-021 SHALL apply a claim and a completion in the same cycle independently (the ids necessarily differ).
REQ-022 SHALL not re-pend a source in the cycle it completes: a level source still high returns to PENDING one cycle after reaching IDLE.
REQ-023 SHALL hold a PENDING source whose enable deasserts in PENDING and mask it from arbitration until re-enabled; io_enable SHALL NOT affect INFLIGHT.
REQ-024 SHALL drop triggers arriving while a source is PENDING or INFLIGHT, except as defined in REQ-030.
REQ-025 SHALL take a changed io_edge_mode effect on the next cycle's trig evaluation without altering existing state.

Reset
REQ-026 SHALL, while reset is high at a clock edge, set all FSMs to IDLE, irq_d to 0, and edge counters to 0.
REQ-027 SHALL give reset priority over claim, complete and trig.
REQ-028 SHALL hold io_pending = 0, io_inflight = 0, io_req_valid = 0 and io_req_id = 0 during the cycle after a reset edge.
REQ-029 SHALL treat a high edge-mode io_irq at reset release as a rising edge, because irq_d was 0.

Configuration
REQ-030 SHALL, with INT_GATEWAY_EDGE_COUNT_EN defined, add per-source 3-bit saturating counters, behaving as follows:
- counter SHALL increment on an edge trigger while the source is PENDING or INFLIGHT;
- counter SHALL saturate at 7;
- on completion with a nonzero count, the source SHALL go INFLIGHT to PENDING directly and the counter SHALL decrement;
- an increment and a decrement in the same cycle SHALL leave the count unchanged.
REQ-031 SHALL, without INT_GATEWAY_EDGE_COUNT_EN, have no counters and drop such edges per REQ-024; level-mode behaviour SHALL be identical in both builds.

Verification
REQ-032 SHALL cover level basic: io_enable=4'hF, io_edge_mode=0, io_irq=4'b0100 at cycle 0 -> io_pending=4'b0100 at cycle 1, io_req_id=2; claim at cycle 1 -> io_inflight=4'b0100 at cycle 2; complete id 2 at cycle 3 with io_irq still high -> IDLE at cycle 4, PENDING at cycle 5.
REQ-033 SHALL cover priority: io_irq=4'b1010 -> io_req_id=1; after claim -> io_req_id=3.
REQ-034 SHALL cover masking: source 0 PENDING, then io_enable[0]=0 -> io_req_valid=0 and io_pending[0]=1; re-enable -> io_req_valid=1, io_req_id=0.
REQ-035 SHALL cover edge with counting: io_edge_mode[1]=1, three pulses on io_irq[1], the first claimed and the next two arriving while INFLIGHT; built with INT_GATEWAY_EDGE_COUNT_EN, three claim/complete rounds are required; built without it, one round then IDLE.
REQ-036 SHALL cover mid-operation reset: sources 0 and 2 INFLIGHT and source 3 PENDING, reset high one cycle -> all outputs 0 the next cycle; level io_irq=4'hF held -> io_pending=4'hF one cycle after reset low.
REQ-037 SHALL cover illegal handshakes: io_claim while io_req_valid=0 and complete id 1 while source 1 is IDLE -> no state change.
